// File: rtl/otbn_pq_pkg.sv
// Shared types and constants for the PQ bignum Keccak lane datapath.
package otbn_pq_pkg;

    typedef enum logic [2:0] {
        OP_XOR    = 3'd0,
        OP_XORR   = 3'd1,
        OP_XORC   = 3'd2,
        OP_PACC   = 3'd3,
        OP_THETAD = 3'd4,
        OP_CHI    = 3'd5,
        OP_ILL6   = 3'd6,
        OP_ILL7   = 3'd7
    } keccak_seq_op_e;

    localparam int KECCAK_NUM_COORD = 5;

    // Keccak rho offsets indexed [x][y], mod 64.
    localparam int RHO_OFFSETS [KECCAK_NUM_COORD][KECCAK_NUM_COORD] = '{
        '{ 0, 36,  3, 41, 18},
        '{ 1, 44, 10, 45,  2},
        '{62,  6, 43, 15, 61},
        '{28, 55, 25, 21, 56},
        '{27, 20, 39,  8, 14}
    };

    function automatic int unsigned rho_offset(logic [2:0] x, logic [2:0] y);
        if (x < 3'd5 && y < 3'd5) begin
            return int'(RHO_OFFSETS[x][y]);
        end
        return 0;
    endfunction

endpackage

// File: rtl/otbn_keccak_rho_rot.sv
// Combinational Keccak rho rotation of one lane by RHO[x][y] mod LaneW.
module otbn_keccak_rho_rot
    import otbn_pq_pkg::*;
#(
    parameter int LaneW = 64
) (
    input  logic [LaneW-1:0] lane_i,
    input  logic [2:0]       x_i,
    input  logic [2:0]       y_i,
    output logic [LaneW-1:0] lane_o
);

    localparam int RW = $clog2(LaneW);

    logic [RW-1:0]      rot_amt;
    logic [2*LaneW-1:0] dbl;

    assign rot_amt = RW'(rho_offset(x_i, y_i) % LaneW);
    // Shifting the doubled lane left leaves the rotated lane in the upper half.
    assign dbl     = {lane_i, lane_i} << rot_amt;
    assign lane_o  = dbl[2*LaneW-1:LaneW];

endmodule

// File: rtl/otbn_keccak_lane_seq.sv
// Pipelined Keccak lane datapath with theta column-parity state and one
// valid/ready output register stage.
module otbn_keccak_lane_seq
    import otbn_pq_pkg::*;
#(
    parameter  int WLEN     = 256,
    parameter  int LaneW    = 64,
    localparam int NumLanes = WLEN / LaneW,
    localparam int LSelW    = $clog2(NumLanes)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  keccak_seq_op_e      op_i,
    input  logic [WLEN-1:0]     operand_a_i,
    input  logic [WLEN-1:0]     operand_b_i,
    input  logic [LaneW-1:0]    rc_i,
    input  logic [LSelW-1:0]    a_sel_i,
    input  logic [LSelW-1:0]    b_sel_i,
    input  logic [LSelW-1:0]    d_sel_i,
    input  logic [2:0]          x_i,
    input  logic [2:0]          y_i,
    input  logic                parity_clr_i,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [WLEN-1:0]     rd_o,
    output logic [NumLanes-1:0] rd_we_o,
    output logic                err_o
);

    logic [LaneW-1:0]    c_q [KECCAK_NUM_COORD];
    logic [LaneW-1:0]    c_d [KECCAK_NUM_COORD];
    logic                valid_q, err_q, err_d;
    logic [WLEN-1:0]     rd_q, rd_d;
    logic [NumLanes-1:0] we_q, we_d;

    logic [LSelW-1:0] c_sel;
    logic [LaneW-1:0] lane_a, lane_b, lane_c, ab, ab_rot, pacc_val, res;
    logic [LaneW-1:0] c_xm1, c_xp1;
    logic [2:0]       x_p1, x_m1;
    logic             accept, pacc_en;

    assign ready_o = !valid_q || ready_i;
    assign accept  = valid_i && ready_o;

    assign c_sel  = b_sel_i + LSelW'(1);
    assign lane_a = operand_a_i[a_sel_i*LaneW +: LaneW];
    assign lane_b = operand_b_i[b_sel_i*LaneW +: LaneW];
    assign lane_c = operand_b_i[c_sel*LaneW +: LaneW];
    assign ab     = lane_a ^ lane_b;

    otbn_keccak_rho_rot #(.LaneW(LaneW)) u_rho_rot (
        .lane_i (ab),
        .x_i    (x_i),
        .y_i    (y_i),
        .lane_o (ab_rot)
    );

    assign x_p1  = (x_i >= 3'd4) ? 3'd0 : x_i + 3'd1;
    assign x_m1  = (x_i == 3'd0) ? 3'd4 : x_i - 3'd1;
    assign c_xp1 = c_q[x_p1];
    assign c_xm1 = c_q[x_m1];

    // A coinciding clear wins over the old C[x], so the accumulation restarts from a^b.
    assign pacc_val = (parity_clr_i ? '0 : c_q[x_i]) ^ ab;

    always_comb begin
        res   = '0;
        err_d = 1'b0;
        unique case (op_i)
            OP_XOR:    res = ab;
            OP_XORR: begin
                res   = ab_rot;
                err_d = (x_i > 3'd4) || (y_i > 3'd4);
            end
            OP_XORC:   res = lane_a ^ rc_i;
            OP_PACC: begin
                res   = pacc_val;
                err_d = (x_i > 3'd4);
            end
            OP_THETAD: begin
                res   = c_xm1 ^ {c_xp1[LaneW-2:0], c_xp1[LaneW-1]};
                err_d = (x_i > 3'd4);
            end
            OP_CHI:    res = lane_a ^ (~lane_b & lane_c);
            default:   err_d = 1'b1;
        endcase
    end

    always_comb begin
        rd_d = '0;
        we_d = '0;
        if (!err_d) begin
            rd_d[d_sel_i*LaneW +: LaneW] = res;
            we_d[d_sel_i]                = 1'b1;
        end
    end

    assign pacc_en = accept && (op_i == OP_PACC) && !err_d;

    always_comb begin
        for (int unsigned i = 0; i < KECCAK_NUM_COORD; i++) begin
            c_d[i] = parity_clr_i ? '0 : c_q[i];
        end
        if (pacc_en) begin
            c_d[x_i] = pacc_val;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < KECCAK_NUM_COORD; i++) begin
                c_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < KECCAK_NUM_COORD; i++) begin
                c_q[i] <= c_d[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            we_q    <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            rd_q    <= rd_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign rd_o    = rd_q;
    assign rd_we_o = we_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_otbn_keccak_lane_seq.sv
// Directed self-checking bench for otbn_keccak_lane_seq (64- and 32-bit lanes).
module tb_otbn_keccak_lane_seq;
    import otbn_pq_pkg::*;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           valid_i = 1'b0, ready_i = 1'b1, parity_clr_i = 1'b0;
    keccak_seq_op_e op_i = OP_XOR;
    logic [255:0]   opa = '0, opb = '0;
    logic [63:0]    rc = '0;
    logic [1:0]     a_sel = '0, b_sel = '0, d_sel = '0;
    logic [2:0]     x = '0, y = '0;
    logic           ready_o, valid_o, err_o;
    logic [255:0]   rd_o;
    logic [3:0]     we_o;

    logic           v32 = 1'b0;
    logic           r32_o, v32_o, e32_o;
    logic [255:0]   rd32_o;
    logic [7:0]     we32_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    otbn_keccak_lane_seq #(.WLEN(256), .LaneW(64)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
        .operand_a_i(opa), .operand_b_i(opb), .rc_i(rc),
        .a_sel_i(a_sel), .b_sel_i(b_sel), .d_sel_i(d_sel), .x_i(x), .y_i(y),
        .parity_clr_i(parity_clr_i), .valid_o(valid_o), .ready_i(ready_i),
        .rd_o(rd_o), .rd_we_o(we_o), .err_o(err_o)
    );

    otbn_keccak_lane_seq #(.WLEN(256), .LaneW(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(v32), .ready_o(r32_o), .op_i(OP_XORR),
        .operand_a_i(256'h1), .operand_b_i(256'h0), .rc_i(32'h0),
        .a_sel_i(3'd0), .b_sel_i(3'd0), .d_sel_i(3'd0), .x_i(3'd1), .y_i(3'd1),
        .parity_clr_i(1'b0), .valid_o(v32_o), .ready_i(1'b1),
        .rd_o(rd32_o), .rd_we_o(we32_o), .err_o(e32_o)
    );

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a, b, c, rc;
        logic [1:0]  as, bs, ds;
        logic [2:0]  x, y;
        logic [63:0] exp;
        logic        exp_err;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] place(input logic [63:0] v, input logic [1:0] d);
        logic [255:0] r;
        r = '0;
        r[d*64 +: 64] = v;
        return r;
    endfunction

    task automatic drive(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [63:0] rcv, input logic [1:0] as,
                         input logic [1:0] bs, input logic [1:0] ds, input logic [2:0] xv,
                         input logic [2:0] yv);
        logic [255:0] av, bv;
        logic [1:0]   cs;
        av = {4{64'hA5A5_5A5A_DEAD_BEEF}};
        bv = {4{64'h3C3C_C3C3_0BAD_F00D}};
        cs = bs + 2'd1;
        av[as*64 +: 64] = a;
        bv[cs*64 +: 64] = c;
        bv[bs*64 +: 64] = b;
        opa = av; opb = bv; rc = rcv;
        op_i = keccak_seq_op_e'(op);
        a_sel = as; b_sel = bs; d_sel = ds; x = xv; y = yv;
        valid_i = 1'b1;
    endtask

    // One accepted request; returns at the negedge after the accepting edge.
    task automatic do_req(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c, input logic [63:0] rcv, input logic [1:0] as,
                          input logic [1:0] bs, input logic [1:0] ds, input logic [2:0] xv,
                          input logic [2:0] yv, input logic clr);
        @(negedge clk);
        drive(op, a, b, c, rcv, as, bs, ds, xv, yv);
        parity_clr_i = clr;
        ready_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        parity_clr_i = 1'b0;
    endtask

    task automatic expect_ok(input string nm, input logic [63:0] v, input logic [1:0] d);
        chk({nm, "_valid"}, valid_o, 1'b1);
        chk({nm, "_rd"}, rd_o, place(v, d));
        chk({nm, "_we"}, we_o, 4'b0001 << d);
        chk({nm, "_err"}, err_o, 1'b0);
    endtask

    task automatic expect_err(input string nm);
        chk({nm, "_valid"}, valid_o, 1'b1);
        chk({nm, "_rd"}, rd_o, '0);
        chk({nm, "_we"}, we_o, 4'b0000);
        chk({nm, "_err"}, err_o, 1'b1);
    endtask

    initial begin
        //          op    a                      b                      c                      rc                     as    bs    ds    x     y     exp                    err
        vecs[0]  = '{3'd0, 64'h0123456789ABCDEF, 64'hFFFFFFFFFFFFFFFF, 64'h0,                64'h0,                2'd0, 2'd0, 2'd2, 3'd0, 3'd0, 64'hFEDCBA9876543210, 1'b0};
        vecs[1]  = '{3'd1, 64'h8000000000000001, 64'h0,                64'h0,                64'h0,                2'd1, 2'd3, 2'd1, 3'd1, 3'd0, 64'h0000000000000003, 1'b0};
        vecs[2]  = '{3'd1, 64'h1234,             64'h0F0F,             64'h0,                64'h0,                2'd0, 2'd1, 2'd3, 3'd0, 3'd0, 64'h1D3B,             1'b0};
        vecs[3]  = '{3'd1, 64'h1,                64'h0,                64'h0,                64'h0,                2'd2, 2'd2, 2'd0, 3'd4, 3'd4, 64'h4000,             1'b0};
        vecs[4]  = '{3'd1, 64'h4,                64'h0,                64'h0,                64'h0,                2'd3, 2'd0, 2'd2, 3'd2, 3'd0, 64'h1,                1'b0};
        vecs[5]  = '{3'd2, 64'hFF00FF00FF00FF00, 64'h0,                64'h0,                64'h0F0F0F0F0F0F0F0F, 2'd3, 2'd0, 2'd0, 3'd6, 3'd0, 64'hF00FF00FF00FF00F, 1'b0};
        vecs[6]  = '{3'd5, 64'hAAAAAAAAAAAAAAAA, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 64'h0,                2'd2, 2'd3, 2'd1, 3'd0, 3'd0, 64'hAAAAA5A5AAAAA5A5, 1'b0};
        vecs[7]  = '{3'd6, 64'h1,                64'h2,                64'h0,                64'h0,                2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 64'h0,                1'b1};
        vecs[8]  = '{3'd7, 64'h1,                64'h2,                64'h0,                64'h0,                2'd0, 2'd0, 2'd3, 3'd0, 3'd0, 64'h0,                1'b1};
        vecs[9]  = '{3'd1, 64'h1,                64'h0,                64'h0,                64'h0,                2'd0, 2'd0, 2'd0, 3'd1, 3'd5, 64'h0,                1'b1};
        vecs[10] = '{3'd4, 64'h0,                64'h0,                64'h0,                64'h0,                2'd0, 2'd0, 2'd0, 3'd5, 3'd0, 64'h0,                1'b1};
        vecs[11] = '{3'd0, 64'hF0,               64'h0F,               64'h0,                64'h0,                2'd1, 2'd2, 2'd3, 3'd7, 3'd7, 64'hFF,               1'b0};
        vecs[12] = '{3'd5, 64'h0,                64'h0,                64'h5555555555555555, 64'h0,                2'd0, 2'd1, 2'd2, 3'd7, 3'd7, 64'h5555555555555555, 1'b0};

        #3 rst = 1'b1;
        #1;
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_rd", rd_o, '0);
        chk("rst_we", we_o, 4'b0000);
        chk("rst_err", err_o, 1'b0);
        chk("rst_ready", ready_o, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].rc, vecs[i].as,
                   vecs[i].bs, vecs[i].ds, vecs[i].x, vecs[i].y, 1'b0);
            if (vecs[i].exp_err) expect_err($sformatf("vec%0d", i));
            else                 expect_ok($sformatf("vec%0d", i), vecs[i].exp, vecs[i].ds);
        end

        // LaneW=32: offset 44 mod 32 = 12.
        @(negedge clk);
        v32 = 1'b1;
        @(negedge clk);
        v32 = 1'b0;
        chk("w32_valid", v32_o, 1'b1);
        chk("w32_rd", rd32_o, 256'h1000);
        chk("w32_we", we32_o, 8'h01);
        chk("w32_err", e32_o, 1'b0);
        chk("w32_ready", r32_o, 1'b1);

        // Column parity accumulation and theta D.
        @(negedge clk);
        parity_clr_i = 1'b1;
        @(negedge clk);
        parity_clr_i = 1'b0;
        do_req(3'd3, 64'h1, 64'h0, 64'h0, 64'h0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0);
        expect_ok("pacc0", 64'h1, 2'd0);
        do_req(3'd3, 64'h2, 64'h0, 64'h0, 64'h0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0);
        expect_ok("pacc1", 64'h3, 2'd0);
        do_req(3'd3, 64'h8000000000000000, 64'h0, 64'h0, 64'h0, 2'd1, 2'd0, 2'd1, 3'd2, 3'd0, 1'b0);
        expect_ok("pacc2", 64'h8000000000000000, 2'd1);
        do_req(3'd4, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 2'd0, 2'd3, 3'd1, 3'd0, 1'b0);
        expect_ok("thetad1", 64'h2, 2'd3);

        // Backpressure: first PACC held three cycles, second must wait.
        @(negedge clk);
        drive(3'd3, 64'h5, 64'h0, 64'h0, 64'h0, 2'd0, 2'd0, 2'd0, 3'd4, 3'd0);
        ready_i = 1'b0;
        @(negedge clk);
        drive(3'd3, 64'h6, 64'h0, 64'h0, 64'h0, 2'd0, 2'd0, 2'd0, 3'd4, 3'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d_ready", i), ready_o, 1'b0);
            chk($sformatf("stall%0d_valid", i), valid_o, 1'b1);
            chk($sformatf("stall%0d_rd", i), rd_o, place(64'h5, 2'd0));
            chk($sformatf("stall%0d_we", i), we_o, 4'b0001);
            @(negedge clk);
        end
        ready_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        expect_ok("pacc_second", 64'h3, 2'd0);
        do_req(3'd4, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0);
        expect_ok("thetad0_a", 64'h3, 2'd0);

        // Illegal coordinate must not touch parity state.
        do_req(3'd3, 64'hFF, 64'h0, 64'h0, 64'h0, 2'd0, 2'd0, 2'd0, 3'd5, 3'd0, 1'b0);
        expect_err("pacc_x5");
        do_req(3'd4, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0);
        expect_ok("thetad0_b", 64'h3, 2'd0);

        // Clear coinciding with PACC, and with THETAD.
        do_req(3'd3, 64'h10, 64'h0, 64'h0, 64'h0, 2'd0, 2'd0, 2'd0, 3'd1, 3'd0, 1'b1);
        expect_ok("pacc_clr", 64'h10, 2'd0);
        do_req(3'd4, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0);
        expect_ok("thetad0_c", 64'h20, 2'd0);
        do_req(3'd4, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b1);
        expect_ok("thetad_clr", 64'h20, 2'd0);
        do_req(3'd4, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1'b0);
        expect_ok("thetad0_d", 64'h0, 2'd0);

        // Reset while a result is stalled.
        do_req(3'd3, 64'h7, 64'h0, 64'h0, 64'h0, 2'd0, 2'd0, 2'd0, 3'd3, 3'd0, 1'b0);
        expect_ok("pacc3", 64'h7, 2'd0);
        @(negedge clk);
        drive(3'd0, 64'h11, 64'h22, 64'h0, 64'h0, 2'd0, 2'd0, 2'd1, 3'd0, 3'd0);
        ready_i = 1'b0;
        @(negedge clk);
        valid_i = 1'b0;
        chk("pre_rst_valid", valid_o, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", valid_o, 1'b0);
        chk("mid_rst_rd", rd_o, '0);
        chk("mid_rst_we", we_o, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        ready_i = 1'b1;
        chk("post_rst_valid", valid_o, 1'b0);
        do_req(3'd0, 64'h11, 64'h22, 64'h0, 64'h0, 2'd0, 2'd0, 2'd1, 3'd0, 3'd0, 1'b0);
        expect_ok("post_rst_xor", 64'h33, 2'd1);
        do_req(3'd4, 64'h0, 64'h0, 64'h0, 64'h0, 2'd0, 2'd0, 2'd0, 3'd4, 3'd0, 1'b0);
        expect_ok("thetad4_rst", 64'h0, 2'd0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
